// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the ALU command front end.
// Holds the opcode encodings (MIPS funct) and the opcode-support check.
package alu_uart_interface_pkg;

  localparam int unsigned OP_ADD = 32;
  localparam int unsigned OP_SUB = 34;
  localparam int unsigned OP_AND = 36;
  localparam int unsigned OP_OR  = 37;
  localparam int unsigned OP_XOR = 38;
  localparam int unsigned OP_SRA = 3;
  localparam int unsigned OP_SRL = 2;
  localparam int unsigned OP_NOR = 39;

  function automatic logic op_is_supported(input int unsigned op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
  endfunction

endpackage

// File: rtl/alu_uart_interface.sv
// Command stage between the UART and the 8-bit ALU: collects A, B, OP bytes,
// presents them to the ALU, then hands the captured result to the transmitter.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_op_error,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StExec,
    StSend,
    StWaitTx
  } state_e;

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               op_error_q, op_error_d;
  logic               timeout_q, timeout_d;
  logic               op_valid;

  // Upper OP bits must be clear; lower bits must be one of the supported functs.
  always_comb begin
    op_valid = (i_rx_data[NB_DATA-1:NB_OP] == '0) &&
               op_is_supported(32'(i_rx_data[NB_OP-1:0]));
  end

  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    cnt_d      = '0;
    op_error_d = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      StWaitA: begin
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          state_d  = StWaitB;
        end
      end
      StWaitB: begin
        if (i_rx_done) begin
          data_b_d = i_rx_data;
          state_d  = StWaitOp;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StWaitA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitOp: begin
        if (i_rx_done) begin
          if (op_valid) begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = StExec;
          end else begin
            op_error_d = 1'b1;
            state_d    = StWaitA;
          end
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StWaitA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StExec: begin
        // Operands and opcode have been stable for a full cycle by now.
        tx_data_d = i_alu_result;
        state_d   = StSend;
      end
      StSend: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (i_tx_done) begin
          state_d = StWaitA;
        end
      end
      default: begin
        state_d = StWaitA;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StWaitA;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      op_error_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      op_error_q <= op_error_d;
      timeout_q  <= timeout_d;
    end
  end

  // Decoded from state so that reset kills a pending start pulse immediately.
  assign o_tx_start   = (state_q == StSend);
  assign o_busy       = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx);
  assign o_alu_data_a = data_a_q;
  assign o_alu_data_b = data_b_q;
  assign o_alu_op     = op_q;
  assign o_tx_data    = tx_data_q;
  assign o_op_error   = op_error_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a behavioural ALU and a result scoreboard.
module tb_alu_uart_interface;

  localparam int unsigned NbData  = 8;
  localparam int unsigned NbOp    = 6;
  localparam int unsigned Timeout = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NbData-1:0] rx_data;
  logic              rx_done;
  logic              tx_done;
  logic [NbData-1:0] alu_result;
  logic [NbData-1:0] alu_a, alu_b, tx_data;
  logic [NbOp-1:0]   alu_op;
  logic              tx_start, busy, op_error, timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  alu_uart_interface #(
    .NB_DATA       (NbData),
    .NB_OP         (NbOp),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_tx_done   (tx_done),
    .i_alu_result(alu_result),
    .o_alu_data_a(alu_a),
    .o_alu_data_b(alu_b),
    .o_alu_op    (alu_op),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_busy      (busy),
    .o_op_error  (op_error),
    .o_timeout   (timeout)
  );

  // Reference ALU: A op B, shift amount taken from B.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      6'd32:   alu_result = alu_a + alu_b;
      6'd34:   alu_result = alu_a - alu_b;
      6'd36:   alu_result = alu_a & alu_b;
      6'd37:   alu_result = alu_a | alu_b;
      6'd38:   alu_result = alu_a ^ alu_b;
      6'd3:    alu_result = 8'($signed(alu_a) >>> alu_b);
      6'd2:    alu_result = alu_a >> alu_b;
      6'd39:   alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'hxx;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({alu_a, alu_b, alu_op, tx_data, tx_start, busy, op_error, timeout}), 32'd0);
  endtask

  // Sends one valid frame and stops in the SEND cycle after scoring the result.
  task automatic run_to_send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [7:0] exp);
    int n;
    send_byte(a);
    send_byte(b);
    sb.push_back(exp);
    send_byte(op);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_op", 32'(alu_op), 32'(op[5:0]));
    n = 0;
    while (tx_start !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    check("start_latency", 32'(n), 32'd1);
    if (sb.size() > 0) check("tx_data", 32'(tx_data), 32'(sb.pop_front()));
  endtask

  task automatic finish_tx();
    tick();
    check("start_one_cycle", 32'({tx_start, busy}), 32'b01);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("idle_after_tx", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    rst     = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset_state");

    // ADD 5 + 3
    run_to_send(8'h05, 8'h03, 8'h20, 8'h08);
    check("t1_a", 32'(alu_a), 32'h05);
    check("t1_b", 32'(alu_b), 32'h03);
    finish_tx();

    // SRA 0x80 by 2
    run_to_send(8'h80, 8'h02, 8'h03, 8'hE0);
    finish_tx();

    // Unsupported opcode, then OR frame
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h21);
    check("op_error_pulse", 32'({op_error, tx_start, busy}), 32'b100);
    check("op_unchanged", 32'(alu_op), 32'd3);
    tick();
    check("op_error_single", 32'({op_error, tx_start}), 32'b00);
    run_to_send(8'h0F, 8'hF0, 8'h25, 8'hFF);
    finish_tx();

    // Timeout after 16 silent cycles in WAIT_B
    send_byte(8'h11);
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (timeout) early = 1'b1;
    end
    tick();
    check("no_early_timeout", 32'(early), 32'd0);
    check("timeout_pulse", 32'(timeout), 32'd1);
    send_byte(8'h99);
    check("timeout_single", 32'(timeout), 32'd0);
    check("after_timeout_a", 32'(alu_a), 32'h99);
    check("operand_b_kept", 32'(alu_b), 32'hF0);

    // A byte arriving in the expiry cycle wins over the timeout
    for (int i = 0; i < 15; i++) tick();
    send_byte(8'h22);
    check("byte_wins_no_to", 32'(timeout), 32'd0);
    check("byte_wins_b", 32'(alu_b), 32'h22);
    sb.push_back(8'hBB);
    send_byte(8'h26);
    tick();
    check("xor_start", 32'(tx_start), 32'd1);
    check("xor_data", 32'(tx_data), 32'(sb.pop_front()));
    tick();

    // Stray rx in WAIT_TX, then rx and tx_done together
    send_byte(8'h77);
    check("drop_rx_busy", 32'(busy), 32'd1);
    check("drop_rx_a", 32'(alu_a), 32'h99);
    rx_data = 8'h66;
    rx_done = 1'b1;
    tx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tx_done = 1'b0;
    check("rx_tx_same_idle", 32'(busy), 32'd0);
    check("rx_tx_same_a", 32'(alu_a), 32'h99);
    send_byte(8'h42);
    check("next_a_accepted", 32'(alu_a), 32'h42);
    send_byte(8'h01);

    // Async reset in WAIT_OP
    #2 rst = 1'b1;
    #1 check_all_zero("reset_in_waitop");
    rst = 1'b0;
    tick();

    // Async reset in SEND
    run_to_send(8'h09, 8'h04, 8'h22, 8'h05);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_in_send");
    rst = 1'b0;
    tick();
    check("no_start_after_rst", 32'(tx_start), 32'd0);

    // Frame after reset: NOR
    run_to_send(8'h12, 8'h21, 8'h27, 8'hCC);
    finish_tx();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
